// File: rtl/ysyx_25030081_pcu_pkg.sv
// Shared definitions for the program-counter unit: control-flow codes and FSM states.
package ysyx_25030081_pcu_pkg;

   // Control-flow codes carried on ex_branch; unlisted codes fall through as "none"
   localparam logic [3:0] BR_NONE  = 4'b0000;
   localparam logic [3:0] BR_JAL   = 4'b0001;
   localparam logic [3:0] BR_JALR  = 4'b0010;
   localparam logic [3:0] BR_BEQ   = 4'b0100;
   localparam logic [3:0] BR_BNE   = 4'b0101;
   localparam logic [3:0] BR_BLT   = 4'b0110;
   localparam logic [3:0] BR_BGE   = 4'b0111;
   localparam logic [3:0] BR_BLTU  = 4'b1110;
   localparam logic [3:0] BR_BGEU  = 4'b1111;
   localparam logic [3:0] BR_ECALL = 4'b1000;
   localparam logic [3:0] BR_MRET  = 4'b1001;

   // FETCH offers the PC to the IFU, EXEC waits for the resolved packet from the EXU
   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_EXEC  = 1'b1
   } pcu_state_e;

endpackage

// File: rtl/ysyx_25030081_bru.sv
// Combinational branch resolution: condition, target, alignment fault and next PC.
module ysyx_25030081_bru
   import ysyx_25030081_pcu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int C_EXT      = 0
) (
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0] src1,
   input  logic [DATA_WIDTH-1:0] src2,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [3:0]            branch,
   input  logic [DATA_WIDTH-1:0] mtvec,
   input  logic [DATA_WIDTH-1:0] mepc,
   output logic [DATA_WIDTH-1:0] next_pc,
   output logic                  taken,
   output logic                  misalign,
   output logic [DATA_WIDTH-1:0] target
);

   localparam logic [DATA_WIDTH-1:0] MASK_HALF = ~DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] MASK_WORD = ~DATA_WIDTH'(3);
   localparam logic [DATA_WIDTH-1:0] STEP      = DATA_WIDTH'(4);

   logic [DATA_WIDTH-1:0] seq_pc;
   logic [DATA_WIDTH-1:0] rel_target;
   logic [DATA_WIDTH-1:0] trap_vec;
   logic                  cond;
   logic                  check_align;

   // Decode the code into a target and a take decision; only pc-relative and jalr targets are alignment-checked
   always_comb begin
      seq_pc      = pc + STEP;
      rel_target  = pc + imm;
      trap_vec    = mtvec & MASK_WORD;
      target      = rel_target;
      cond        = 1'b0;
      check_align = 1'b0;
      case (branch)
         BR_JAL:   begin cond = 1'b1; check_align = 1'b1; end
         BR_JALR:  begin target = (src1 + imm) & MASK_HALF; cond = 1'b1; check_align = 1'b1; end
         BR_BEQ:   begin cond = (src1 == src2); check_align = cond; end
         BR_BNE:   begin cond = (src1 != src2); check_align = cond; end
         BR_BLT:   begin cond = ($signed(src1) <  $signed(src2)); check_align = cond; end
         BR_BGE:   begin cond = ($signed(src1) >= $signed(src2)); check_align = cond; end
         BR_BLTU:  begin cond = (src1 <  src2); check_align = cond; end
         BR_BGEU:  begin cond = (src1 >= src2); check_align = cond; end
         BR_ECALL: begin target = trap_vec; cond = 1'b1; end
         BR_MRET:  begin target = mepc & MASK_HALF; cond = 1'b1; end
         default:  ;
      endcase
      // bit 0 is always clear here, so only bit 1 can break 4-byte alignment
      misalign = check_align && (C_EXT == 0) && target[1];
      taken    = cond && !misalign;
      if (misalign)
         next_pc = trap_vec;
      else if (cond)
         next_pc = target;
      else
         next_pc = seq_pc;
   end

endmodule

// File: rtl/ysyx_25030081_pcu.sv
// Program-counter unit: holds the PC, hands it to the IFU, retires one EXU packet per instruction.
module ysyx_25030081_pcu
   import ysyx_25030081_pcu_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
   parameter int                    C_EXT      = 0,
   parameter int                    CNT_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  pc_valid,
   input  logic                  pc_ready,
   output logic [DATA_WIDTH-1:0] pc,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [3:0]            ex_branch,
   input  logic [DATA_WIDTH-1:0] ex_src1,
   input  logic [DATA_WIDTH-1:0] ex_src2,
   input  logic [DATA_WIDTH-1:0] ex_imm,
   input  logic [DATA_WIDTH-1:0] mtvec,
   input  logic [DATA_WIDTH-1:0] mepc,
   output logic                  taken,
   output logic                  misalign,
   output logic [DATA_WIDTH-1:0] mtval,
   output logic [CNT_WIDTH-1:0]  instret
);

   pcu_state_e            state_reg, state_next;
   logic [DATA_WIDTH-1:0] pc_reg;
   logic                  taken_reg;
   logic                  misalign_reg;
   logic [DATA_WIDTH-1:0] mtval_reg;
   logic [CNT_WIDTH-1:0]  instret_reg;
   logic                  ex_fire;

   logic [DATA_WIDTH-1:0] bru_next_pc;
   logic                  bru_taken;
   logic                  bru_misalign;
   logic [DATA_WIDTH-1:0] bru_target;

   ysyx_25030081_bru #(
      .DATA_WIDTH (DATA_WIDTH),
      .C_EXT      (C_EXT)
   ) u_bru (
      .pc       (pc_reg),
      .src1     (ex_src1),
      .src2     (ex_src2),
      .imm      (ex_imm),
      .branch   (ex_branch),
      .mtvec    (mtvec),
      .mepc     (mepc),
      .next_pc  (bru_next_pc),
      .taken    (bru_taken),
      .misalign (bru_misalign),
      .target   (bru_target)
   );

   // Handshake FSM; request/accept strobes come from state alone (rst_n masks the request during reset)
   always_comb begin
      state_next = state_reg;
      pc_valid   = 1'b0;
      ex_ready   = 1'b0;
      ex_fire    = 1'b0;
      case (state_reg)
         ST_FETCH: begin
            pc_valid = rst_n;
            if (pc_ready) state_next = ST_EXEC;
         end
         ST_EXEC: begin
            ex_ready = 1'b1;
            ex_fire  = ex_valid;
            if (ex_valid) state_next = ST_FETCH;
         end
         default: state_next = ST_FETCH;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_FETCH;
      else        state_reg <= state_next;
   end

   // Architectural state: PC, one-cycle pulses, sticky fault address and retired count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg       <= RESET_PC;
         taken_reg    <= 1'b0;
         misalign_reg <= 1'b0;
         mtval_reg    <= '0;
         instret_reg  <= '0;
      end else begin
         taken_reg    <= ex_fire && bru_taken;
         misalign_reg <= ex_fire && bru_misalign;
         if (ex_fire) begin
            pc_reg      <= bru_next_pc;
            instret_reg <= instret_reg + CNT_WIDTH'(1);
            if (bru_misalign) mtval_reg <= bru_target;
         end
      end
   end

   assign pc       = pc_reg;
   assign taken    = taken_reg;
   assign misalign = misalign_reg;
   assign mtval    = mtval_reg;
   assign instret  = instret_reg;

endmodule

// File: tb/tb_ysyx_25030081_pcu.sv
// Bench for the PCU: two instances (word-aligned with 64-bit counter, C_EXT with 4-bit counter)
// share stimulus and are compared every cycle against an instruction-level reference model.
module tb_ysyx_25030081_pcu;

   logic        clk;
   logic        rst_n;
   logic        pc_ready;
   logic        ex_valid;
   logic [3:0]  ex_branch;
   logic [31:0] ex_src1, ex_src2, ex_imm, mtvec, mepc;

   logic        a_pc_valid, a_ex_ready, a_taken, a_misalign;
   logic [31:0] a_pc, a_mtval;
   logic [63:0] a_instret;
   logic        b_pc_valid, b_ex_ready, b_taken, b_misalign;
   logic [31:0] b_pc, b_mtval;
   logic [3:0]  b_instret;

   int passed = 0;
   int total  = 0;

   ysyx_25030081_pcu #(.DATA_WIDTH(32), .RESET_PC(32'h8000_0000), .C_EXT(0), .CNT_WIDTH(64)) dut_a (
      .clk(clk), .rst_n(rst_n), .pc_valid(a_pc_valid), .pc_ready(pc_ready), .pc(a_pc),
      .ex_valid(ex_valid), .ex_ready(a_ex_ready), .ex_branch(ex_branch), .ex_src1(ex_src1),
      .ex_src2(ex_src2), .ex_imm(ex_imm), .mtvec(mtvec), .mepc(mepc), .taken(a_taken),
      .misalign(a_misalign), .mtval(a_mtval), .instret(a_instret));

   ysyx_25030081_pcu #(.DATA_WIDTH(32), .RESET_PC(32'h8000_0000), .C_EXT(1), .CNT_WIDTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .pc_valid(b_pc_valid), .pc_ready(pc_ready), .pc(b_pc),
      .ex_valid(ex_valid), .ex_ready(b_ex_ready), .ex_branch(ex_branch), .ex_src1(ex_src1),
      .ex_src2(ex_src2), .ex_imm(ex_imm), .mtvec(mtvec), .mepc(mepc), .taken(b_taken),
      .misalign(b_misalign), .mtval(b_mtval), .instret(b_instret));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model, per instance: 0 = word alignment / 64-bit count, 1 = C_EXT / 4-bit count
   bit          m_busy    [2];   // 1 while the fetched instruction awaits its EXU packet
   logic [31:0] m_pc      [2];
   bit          m_taken   [2];
   bit          m_mis     [2];
   logic [31:0] m_mtval   [2];
   logic [63:0] m_instret [2];

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            m_busy[d] = 0; m_pc[d] = 32'h8000_0000; m_taken[d] = 0;
            m_mis[d] = 0; m_mtval[d] = 0; m_instret[d] = 0;
         end else if (!m_busy[d]) begin
            m_taken[d] = 0; m_mis[d] = 0;
            if (pc_ready) m_busy[d] = 1;
         end else if (!ex_valid) begin
            m_taken[d] = 0; m_mis[d] = 0;
         end else begin
            logic [31:0] tgt;
            bit          go, chk;
            tgt = m_pc[d] + ex_imm;
            go = 0; chk = 0;
            case (ex_branch)
               4'd1:  begin go = 1; chk = 1; end
               4'd2:  begin tgt = (ex_src1 + ex_imm) & 32'hFFFF_FFFE; go = 1; chk = 1; end
               4'd4:  go = (ex_src1 == ex_src2);
               4'd5:  go = (ex_src1 != ex_src2);
               4'd6:  go = ($signed(ex_src1) <  $signed(ex_src2));
               4'd7:  go = ($signed(ex_src1) >= $signed(ex_src2));
               4'd14: go = (ex_src1 <  ex_src2);
               4'd15: go = (ex_src1 >= ex_src2);
               4'd8:  begin tgt = mtvec & 32'hFFFF_FFFC; go = 1; end
               4'd9:  begin tgt = mepc & 32'hFFFF_FFFE; go = 1; end
               default: go = 0;
            endcase
            if (ex_branch[2]) chk = go;
            if (chk && d == 0 && (tgt % 4) != 0) begin
               m_pc[d] = mtvec & 32'hFFFF_FFFC; m_mis[d] = 1; m_taken[d] = 0; m_mtval[d] = tgt;
            end else begin
               m_pc[d] = go ? tgt : m_pc[d] + 32'd4; m_mis[d] = 0; m_taken[d] = go;
            end
            m_instret[d] = (d == 0) ? m_instret[d] + 1 : (m_instret[d] + 1) % 16;
            m_busy[d] = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Every-cycle comparison of both instances against the model
   task automatic compare_all();
      chk("a.pc_valid", 64'(a_pc_valid), 64'(!m_busy[0] && rst_n));
      chk("a.ex_ready", 64'(a_ex_ready), 64'(m_busy[0]));
      chk("a.pc",       64'(a_pc),       64'(m_pc[0]));
      chk("a.taken",    64'(a_taken),    64'(m_taken[0]));
      chk("a.misalign", 64'(a_misalign), 64'(m_mis[0]));
      chk("a.mtval",    64'(a_mtval),    64'(m_mtval[0]));
      chk("a.instret",  a_instret,       m_instret[0]);
      chk("b.pc_valid", 64'(b_pc_valid), 64'(!m_busy[1] && rst_n));
      chk("b.ex_ready", 64'(b_ex_ready), 64'(m_busy[1]));
      chk("b.pc",       64'(b_pc),       64'(m_pc[1]));
      chk("b.taken",    64'(b_taken),    64'(m_taken[1]));
      chk("b.misalign", 64'(b_misalign), 64'(m_mis[1]));
      chk("b.mtval",    64'(b_mtval),    64'(m_mtval[1]));
      chk("b.instret",  64'(b_instret),  m_instret[1]);
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
   endtask

   // One instruction from FETCH with both handshakes held high: 2 cycles, back in FETCH
   task automatic instr(input logic [3:0] br, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] imm, input string nm);
      ex_branch = br; ex_src1 = s1; ex_src2 = s2; ex_imm = imm;
      pc_ready = 1'b1; ex_valid = 1'b1;
      tick();
      tick();
      $display("instr %-6s br=%b src1=%h src2=%h imm=%h -> a.pc=%h b.pc=%h taken=%b/%b mis=%b",
               nm, br, s1, s2, imm, a_pc, b_pc, a_taken, b_taken, a_misalign);
   endtask

   initial begin
      rst_n = 1'b1; pc_ready = 1'b0; ex_valid = 1'b0; ex_branch = 4'd0;
      ex_src1 = 0; ex_src2 = 0; ex_imm = 0;
      mtvec = 32'h8000_0105; mepc = 32'h8000_0041;
      #1 rst_n = 1'b0;
      tick(); tick();
      chk("rst.pc",       64'(a_pc), 64'h8000_0000);
      chk("rst.pc_valid", 64'(a_pc_valid), 64'd0);
      chk("rst.instret",  a_instret, 64'd0);
      chk("rst.mtval",    64'(a_mtval), 64'd0);
      rst_n = 1'b1;
      #1 chk("rst.release_pc_valid", 64'(a_pc_valid), 64'd1);

      instr(4'b0000, 0, 0, 0, "none");
      chk("seq.pc1", 64'(a_pc), 64'h8000_0004);
      chk("seq.instret1", a_instret, 64'd1);
      instr(4'b0000, 0, 0, 0, "none");
      chk("seq.pc2", 64'(a_pc), 64'h8000_0008);
      chk("seq.instret2", a_instret, 64'd2);
      instr(4'b0000, 0, 0, 0, "none");
      instr(4'b0000, 0, 0, 0, "none");
      chk("seq.pc4", 64'(a_pc), 64'h8000_0010);

      instr(4'b0101, 5, 5, 32'hFFFF_FFF0, "bne");
      chk("bne.pc", 64'(a_pc), 64'h8000_0014);
      chk("bne.taken", 64'(a_taken), 64'd0);
      instr(4'b0100, 5, 5, 32'hFFFF_FFEC, "beq");
      chk("beq.pc", 64'(a_pc), 64'h8000_0000);
      chk("beq.taken", 64'(a_taken), 64'd1);
      instr(4'b0110, 32'hFFFF_FFFF, 1, 8, "blt");
      chk("blt.pc", 64'(a_pc), 64'h8000_0008);
      chk("blt.taken", 64'(a_taken), 64'd1);
      instr(4'b1110, 32'hFFFF_FFFF, 1, 8, "bltu");
      chk("bltu.pc", 64'(a_pc), 64'h8000_000C);
      chk("bltu.taken", 64'(a_taken), 64'd0);
      instr(4'b0111, 1, 32'hFFFF_FFFF, 4, "bge");
      chk("bge.pc", 64'(a_pc), 64'h8000_0010);
      instr(4'b1111, 1, 32'hFFFF_FFFF, 4, "bgeu");
      chk("bgeu.pc", 64'(a_pc), 64'h8000_0014);

      instr(4'b0010, 32'h8000_1003, 0, 0, "jalr");
      chk("jalr.a.pc", 64'(a_pc), 64'h8000_0104);
      chk("jalr.a.misalign", 64'(a_misalign), 64'd1);
      chk("jalr.a.mtval", 64'(a_mtval), 64'h8000_1002);
      chk("jalr.a.taken", 64'(a_taken), 64'd0);
      chk("jalr.b.pc", 64'(b_pc), 64'h8000_1002);
      chk("jalr.b.taken", 64'(b_taken), 64'd1);
      instr(4'b1000, 0, 0, 0, "ecall");
      chk("ecall.b.pc", 64'(b_pc), 64'h8000_0104);
      instr(4'b1001, 0, 0, 0, "mret");
      chk("mret.a.pc", 64'(a_pc), 64'h8000_0040);
      instr(4'b0100, 3, 3, 6, "beq");
      chk("beqmis.a.mtval", 64'(a_mtval), 64'h8000_0046);
      chk("beqmis.b.pc", 64'(b_pc), 64'h8000_0046);
      instr(4'b1001, 0, 0, 0, "mret");
      instr(4'b0001, 0, 0, 32'h100, "jal");
      chk("jal.pc", 64'(a_pc), 64'h8000_0140);
      instr(4'b0011, 0, 0, 32'h100, "undef");
      chk("undef.pc", 64'(a_pc), 64'h8000_0144);
      chk("cnt.a", a_instret, 64'd17);
      chk("cnt.b_wrapped", 64'(b_instret), 64'd1);

      mtvec = 32'hFFFF_FFFC;
      instr(4'b1000, 0, 0, 0, "ecall");
      chk("wrap.pre", 64'(a_pc), 64'hFFFF_FFFC);
      instr(4'b0000, 0, 0, 0, "none");
      chk("wrap.pc", 64'(a_pc), 64'h0000_0000);

      // IFU stall: PC held, EXU packets ignored in FETCH
      pc_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ex_valid = i[0];
         tick();
         chk("stall.pc", 64'(a_pc), 64'h0);
         chk("stall.ex_ready", 64'(a_ex_ready), 64'd0);
         $display("stall cycle %0d pc=%h pc_valid=%b ex_ready=%b", i, a_pc, a_pc_valid, a_ex_ready);
      end
      chk("stall.instret", a_instret, 64'd19);

      // Enter EXEC, hold there without a packet, then reset asynchronously mid-instruction
      pc_ready = 1'b1; ex_valid = 1'b0;
      tick();
      pc_ready = 1'b0;
      tick();
      chk("exec.ex_ready", 64'(a_ex_ready), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.pc", 64'(a_pc), 64'h8000_0000);
      chk("arst.instret", a_instret, 64'd0);
      chk("arst.pc_valid", 64'(a_pc_valid), 64'd0);
      chk("arst.ex_ready", 64'(a_ex_ready), 64'd0);
      $display("async reset mid-EXEC pc=%h instret=%0d", a_pc, a_instret);
      tick();
      rst_n = 1'b1;
      #1 chk("arst.release_pc_valid", 64'(a_pc_valid), 64'd1);
      instr(4'b0000, 0, 0, 0, "none");
      chk("post.pc", 64'(a_pc), 64'h8000_0004);
      chk("post.instret", a_instret, 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
